// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: bus widths, default NOP encoding and the
// {pc+4, instruction} pair handed to the IF/ID register.
package if_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] IF_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc4;
    logic [INSTR_W-1:0] instr;
  } fetch_pair_t;

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with flush; wrap-around pointers carry an extra MSB so
// full and empty are distinguished without a separate counter.
module fetch_fifo #(
  parameter  int unsigned W     = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_full;
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_count = r_wr - r_rd;
  assign o_data  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_ONE;
      if (w_pop)  r_rd <= r_rd + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order reads
// and presents {pc+4, instr} to IF/ID, with stall and redirect/flush.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
  parameter int unsigned        DEPTH     = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic               clk_i,
  input  logic               rst_n,
  if_fetch_unit_if.master    imem,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_addr_o,
  output logic [INSTR_W-1:0] pc_instr_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned EW    = AW + 1;
  localparam int unsigned TAG_W = ADDR_W + EW;
  localparam int unsigned BUF_W = $bits(fetch_pair_t);
  localparam logic [AW+1:0] CREDITS = (AW+2)'(DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [EW-1:0]     r_epoch;

  logic              w_req;
  logic              w_fire;
  logic [AW:0]       w_tag_cnt;
  logic [AW:0]       w_buf_cnt;
  logic [AW+1:0]     w_used;
  logic              w_tag_empty;
  logic [TAG_W-1:0]  w_tag_q;
  logic [ADDR_W-1:0] w_tag_pc;
  logic [EW-1:0]     w_tag_epoch;
  logic              w_buf_push;
  logic              w_buf_pop;
  logic              w_buf_empty;
  fetch_pair_t       w_buf_in;
  fetch_pair_t       w_head;

  // Credits cover both in-flight reads and buffered instructions, so a
  // returning response always finds room in the buffer.
  assign w_used = {1'b0, w_tag_cnt} + {1'b0, w_buf_cnt};
  assign w_req  = rst_n & ~redirect_i & (w_used < CREDITS);
  assign w_fire = w_req & imem.gnt;

  assign imem.req  = w_req;
  assign imem.addr = r_pc;

  assign w_tag_pc    = w_tag_q[TAG_W-1:EW];
  assign w_tag_epoch = w_tag_q[EW-1:0];

  // Responses from an older epoch still pop their tag (returning the credit)
  // but never reach the buffer.
  assign w_buf_push     = imem.rvalid & ~w_tag_empty & ~redirect_i & (w_tag_epoch == r_epoch);
  assign w_buf_in.pc4   = next_pc(w_tag_pc);
  assign w_buf_in.instr = imem.rdata;

  assign valid_o    = ~w_buf_empty;
  assign w_buf_pop  = valid_o & ~stall_i & ~redirect_i;
  assign pc_addr_o  = valid_o ? w_head.pc4   : '0;
  assign pc_instr_o = valid_o ? w_head.instr : NOP_INSTR;

  // Epoch is a counter rather than a single toggle bit so that up to DEPTH
  // back-to-back redirects cannot alias with a still-outstanding tag.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_epoch <= '0;
    end else if (redirect_i) begin
      r_pc    <= redirect_pc_i;
      r_epoch <= r_epoch + EW'(1);
    end else if (w_fire) begin
      r_pc    <= next_pc(r_pc);
    end
  end

  fetch_fifo #(
    .W     (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .i_flush (1'b0),
    .i_push  (w_fire),
    .i_data  ({r_pc, r_epoch}),
    .i_pop   (imem.rvalid),
    .o_data  (w_tag_q),
    .o_empty (w_tag_empty),
    .o_count (w_tag_cnt)
  );

  fetch_fifo #(
    .W     (BUF_W),
    .DEPTH (DEPTH)
  ) u_instr_buf (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .i_flush (redirect_i),
    .i_push  (w_buf_push),
    .i_data  (w_buf_in),
    .i_pop   (w_buf_pop),
    .o_data  (w_head),
    .o_empty (w_buf_empty),
    .o_count (w_buf_cnt)
  );

  a_rvalid_has_tag: assert property (@(posedge clk_i) disable iff (!rst_n)
    imem.rvalid |-> !w_tag_empty);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a memory responder with random grant
// and latency, a reference PC model and per-scenario directed checks.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic [31:0] pc_addr_o;
  logic [31:0] pc_instr_o;

  if_fetch_unit_if dif ();

  if_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i         (clk),
    .rst_n         (rst_n),
    .imem          (dif),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .pc_addr_o     (pc_addr_o),
    .pc_instr_o    (pc_instr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_deliv = 0;
  bit saw_wrap = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory responder ----------------
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  pend_t       pend_q[$];
  int unsigned cyc      = 0;
  int unsigned lat_min  = 0;
  int unsigned lat_max  = 0;
  int unsigned gnt_wait = 0;

  initial begin
    logic        hs;
    logic [31:0] ha;
    dif.gnt    = 1'b0;
    dif.rvalid = 1'b0;
    dif.rdata  = '0;
    forever begin
      @(negedge clk);
      hs = (dif.req === 1'b1) && (dif.gnt === 1'b1);
      ha = dif.addr;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n !== 1'b1) begin
        pend_q.delete();
        dif.gnt    = 1'b0;
        dif.rvalid = 1'b0;
      end else begin
        if (hs) pend_q.push_back('{addr: ha, due: cyc + lat_min + $urandom_range(0, lat_max - lat_min)});
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          dif.rvalid = 1'b1;
          dif.rdata  = mem_word(pend_q[0].addr);
          void'(pend_q.pop_front());
        end else begin
          dif.rvalid = 1'b0;
          dif.rdata  = $urandom;
        end
        dif.gnt = ($urandom_range(0, gnt_wait) == 0);
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  fetch_pair_t exp_q[$];
  logic [31:0] m_pc = RESET_PC;
  int          m_inflight = 0;
  int          m_stale = 0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      m_pc = RESET_PC;
      exp_q.delete();
      m_inflight = 0;
      m_stale = 0;
    end else begin
      if (valid_o === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_head: valid_o=1 with pc4=%h instr=%h, required nothing pending", pc_addr_o, pc_instr_o);
        end else if ({pc_addr_o, pc_instr_o} !== {exp_q[0].pc4, exp_q[0].instr}) begin
          n_err++;
          $display("FAIL sb_head: got pc4=%h instr=%h, required pc4=%h instr=%h",
                   pc_addr_o, pc_instr_o, exp_q[0].pc4, exp_q[0].instr);
        end
        if (pc_addr_o === 32'h0) saw_wrap = 1;
      end
      if (dif.rvalid === 1'b1 && m_inflight > 0) begin
        m_inflight--;
        if (m_stale > 0) m_stale--;
      end
      if (redirect_i === 1'b1) begin
        n_cmp++;
        if (dif.req !== 1'b0) begin
          n_err++;
          $display("FAIL redirect_req: imem_req_o=%b during redirect, required 0", dif.req);
        end
        exp_q.delete();
        m_stale = m_inflight;
        m_pc = redirect_pc_i;
      end else begin
        if (valid_o === 1'b1 && stall_i === 1'b0 && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          n_deliv++;
        end
        if (dif.req === 1'b1 && dif.gnt === 1'b1) begin
          n_cmp++;
          if (dif.addr !== m_pc) begin
            n_err++;
            $display("FAIL req_addr: got %h, required %h", dif.addr, m_pc);
          end
          exp_q.push_back('{pc4: m_pc + 32'd4, instr: mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
          m_inflight++;
        end
      end
      n_cmp++;
      if (exp_q.size() + m_stale > int'(DEPTH)) begin
        n_err++;
        $display("FAIL credits: outstanding=%0d, required <= %0d", exp_q.size() + m_stale, DEPTH);
      end
    end
  end

  task automatic wait_valid(input int unsigned max_cyc, output bit ok);
    ok = 0;
    for (int unsigned i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (dif.req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b, required 0", dif.req); end
    n_cmp++;
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", valid_o); end
    n_cmp++;
    if (pc_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_pc_addr: got %h, required 0", pc_addr_o); end
    n_cmp++;
    if (pc_instr_o !== NOP) begin n_err++; $display("FAIL reset_instr: got %h, required %h", pc_instr_o, NOP); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dif.req !== 1'b1 || dif.addr !== RESET_PC) begin
      n_err++;
      $display("FAIL first_req: got req=%b addr=%h, required req=1 addr=%h", dif.req, dif.addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    bit ok;
    int d0;
    d0 = n_deliv;
    wait_valid(20, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL stream_first: valid_o stayed 0, required 1");
    end else if (pc_addr_o !== 32'h4 || pc_instr_o !== mem_word(32'h0)) begin
      n_err++;
      $display("FAIL stream_first: got %h/%h, required %h/%h", pc_addr_o, pc_instr_o, 32'h4, mem_word(32'h0));
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (n_deliv - d0 < 15) begin
      n_err++;
      $display("FAIL stream_rate: delivered %0d in 30 cycles, required >= 15", n_deliv - d0);
    end
  endtask

  task automatic test_stall();
    bit          ok;
    int          grants;
    int          d0;
    logic [31:0] h_pc;
    logic [31:0] h_in;
    @(posedge clk);
    #1 stall_i = 1'b1;
    wait_valid(20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL stall_valid: valid_o stayed 0, required 1"); end
    h_pc = pc_addr_o;
    h_in = pc_instr_o;
    grants = 0;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (valid_o !== 1'b1 || pc_addr_o !== h_pc || pc_instr_o !== h_in) begin
        n_err++;
        $display("FAIL stall_hold: got v=%b %h/%h, required v=1 %h/%h", valid_o, pc_addr_o, pc_instr_o, h_pc, h_in);
      end
      if (dif.req === 1'b1 && dif.gnt === 1'b1) grants++;
    end
    n_cmp++;
    if (dif.req !== 1'b0) begin n_err++; $display("FAIL stall_req: imem_req_o=%b after credits used, required 0", dif.req); end
    n_cmp++;
    if (grants > int'(DEPTH)) begin n_err++; $display("FAIL stall_grants: got %0d, required <= %0d", grants, DEPTH); end
    @(posedge clk);
    #1 stall_i = 1'b0;
    d0 = n_deliv;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (n_deliv - d0 < 4) begin n_err++; $display("FAIL stall_resume: delivered %0d, required >= 4", n_deliv - d0); end
  endtask

  task automatic test_redirect();
    bit ok;
    bit found;
    lat_min = 3;
    lat_max = 3;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (m_inflight == 2 && dif.rvalid !== 1'b1) begin found = 1; break; end
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL redir_setup: never saw 2 requests in flight, required 2"); end
    @(posedge clk);
    #1 redirect_i = 1'b1; redirect_pc_i = 32'h100;
    @(posedge clk);
    #1 redirect_i = 1'b0;
    lat_min = 0;
    lat_max = 1;
    wait_valid(40, ok);
    n_cmp++;
    if (!ok || pc_addr_o !== 32'h104 || pc_instr_o !== mem_word(32'h100)) begin
      n_err++;
      $display("FAIL redir_first: got v=%b %h/%h, required v=1 %h/%h", valid_o, pc_addr_o, pc_instr_o, 32'h104, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_stall();
    bit ok;
    lat_min = 0;
    lat_max = 2;
    @(posedge clk);
    #1 stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h180;
    @(posedge clk);
    #1 redirect_pc_i = 32'h200;
    @(posedge clk);
    #1 redirect_i = 1'b0; stall_i = 1'b0;
    wait_valid(40, ok);
    n_cmp++;
    if (!ok || pc_addr_o !== 32'h204 || pc_instr_o !== mem_word(32'h200)) begin
      n_err++;
      $display("FAIL redir2_first: got v=%b %h/%h, required v=1 %h/%h", valid_o, pc_addr_o, pc_instr_o, 32'h204, mem_word(32'h200));
    end
  endtask

  task automatic test_random_wrap();
    int d0;
    saw_wrap = 0;
    lat_min  = 0;
    lat_max  = 4;
    gnt_wait = 2;
    @(posedge clk);
    #1 redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFC0;
    @(posedge clk);
    #1 redirect_i = 1'b0;
    d0 = n_deliv;
    repeat (400) begin
      @(posedge clk);
      #1 stall_i = ($urandom_range(0, 3) == 0);
    end
    stall_i  = 1'b0;
    gnt_wait = 0;
    lat_max  = 1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (!saw_wrap) begin n_err++; $display("FAIL wrap: pc_addr_o=0 never seen valid, required wrap from FFFFFFFC"); end
    n_cmp++;
    if (n_deliv - d0 < 30) begin n_err++; $display("FAIL random_rate: delivered %0d, required >= 30", n_deliv - d0); end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    bit found;
    lat_min = 3;
    lat_max = 3;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (m_inflight > 0) begin found = 1; break; end
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL rst_setup: no request in flight, required >= 1"); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dif.req !== 1'b0 || valid_o !== 1'b0 || pc_addr_o !== 32'h0 || pc_instr_o !== NOP) begin
      n_err++;
      $display("FAIL rst_async: got req=%b v=%b %h/%h, required req=0 v=0 %h/%h",
               dif.req, valid_o, pc_addr_o, pc_instr_o, 32'h0, NOP);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    lat_min = 0;
    lat_max = 1;
    wait_valid(30, ok);
    n_cmp++;
    if (!ok || pc_addr_o !== RESET_PC + 32'd4 || pc_instr_o !== mem_word(RESET_PC)) begin
      n_err++;
      $display("FAIL rst_restart: got v=%b %h/%h, required v=1 %h/%h",
               valid_o, pc_addr_o, pc_instr_o, RESET_PC + 32'd4, mem_word(RESET_PC));
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_random_wrap();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
